// File: rtl/alu_control_pkg.sv
// ============================================================================
// Module      : alu_control_pkg
// Description : ALU-control constants: ALUOp classes, opcodes, functs, ALU codes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_control_pkg;

    // Operation class from main control
    localparam logic [1:0] ALUOP_MEM = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;
    localparam logic [1:0] ALUOP_I   = 2'b11;

    // R-type opcode groups
    localparam logic [3:0] OPC_R_ARITH = 4'b0000;
    localparam logic [3:0] OPC_R_LOGIC = 4'b0001;
    localparam logic [3:0] OPC_R_SHIFT = 4'b0010;

    // I-type opcodes
    localparam logic [3:0] OPC_ADDI = 4'b1001;
    localparam logic [3:0] OPC_SLTI = 4'b1010;
    localparam logic [3:0] OPC_ANDI = 4'b1011;
    localparam logic [3:0] OPC_ORI  = 4'b1100;

    localparam logic [1:0] FUNCT_0 = 2'b00;
    localparam logic [1:0] FUNCT_1 = 2'b01;
    localparam logic [1:0] FUNCT_2 = 2'b10;
    localparam logic [1:0] FUNCT_3 = 2'b11;

    typedef logic [3:0] alu_code_t;

    localparam alu_code_t ALU_AND = 4'b0000;
    localparam alu_code_t ALU_OR  = 4'b0001;
    localparam alu_code_t ALU_ADD = 4'b0010;
    localparam alu_code_t ALU_XOR = 4'b0011;
    localparam alu_code_t ALU_SLL = 4'b1000;
    localparam alu_code_t ALU_SRL = 4'b1001;
    localparam alu_code_t ALU_SUB = 4'b0110;
    localparam alu_code_t ALU_SLT = 4'b0111;
    localparam alu_code_t ALU_NOR = 4'b1100;

endpackage

`default_nettype wire

// File: rtl/alu_control_decode.sv
// ============================================================================
// Module      : alu_control_decode
// Description : Combinational ALUOp/Opcode/Funct decoder. XOR/NOR shift-group
//               extension enabled by macro ALU_CONTROL_LOGIC_EXT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_control_decode
    import alu_control_pkg::*;
#(
    parameter logic [3:0] DEFAULT_CTRL = 4'b0010
) (
    input  logic [1:0] alu_op_i,
    input  logic [3:0] opcode_i,
    input  logic [1:0] funct_i,
    output logic [3:0] alu_ctrl_o,
    output logic       illegal_o
);

    alu_code_t w_code;
    logic      w_hit;

    // Opcode/Funct are only examined inside the classes that use them, so
    // unknowns on don't-care fields never reach the outputs.
    always_comb begin
        w_code = ALU_ADD;
        w_hit  = 1'b0;
        case (alu_op_i)
            ALUOP_MEM: begin w_code = ALU_ADD; w_hit = 1'b1; end
            ALUOP_BR:  begin w_code = ALU_SUB; w_hit = 1'b1; end
            ALUOP_R: begin
                case (opcode_i)
                    OPC_R_ARITH: begin
                        case (funct_i)
                            FUNCT_0: begin w_code = ALU_ADD; w_hit = 1'b1; end
                            FUNCT_1: begin w_code = ALU_SUB; w_hit = 1'b1; end
                            FUNCT_2: begin w_code = ALU_SLT; w_hit = 1'b1; end
                            default: ;
                        endcase
                    end
                    OPC_R_LOGIC: begin
                        case (funct_i)
                            FUNCT_0: begin w_code = ALU_AND; w_hit = 1'b1; end
                            FUNCT_1: begin w_code = ALU_OR;  w_hit = 1'b1; end
                            default: ;
                        endcase
                    end
                    OPC_R_SHIFT: begin
                        case (funct_i)
                            FUNCT_0: begin w_code = ALU_SLL; w_hit = 1'b1; end
                            FUNCT_1: begin w_code = ALU_SRL; w_hit = 1'b1; end
`ifdef ALU_CONTROL_LOGIC_EXT_EN
                            FUNCT_2: begin w_code = ALU_XOR; w_hit = 1'b1; end
                            FUNCT_3: begin w_code = ALU_NOR; w_hit = 1'b1; end
`endif
                            default: ;
                        endcase
                    end
                    default: ;
                endcase
            end
            ALUOP_I: begin
                case (opcode_i)
                    OPC_ADDI: begin w_code = ALU_ADD; w_hit = 1'b1; end
                    OPC_SLTI: begin w_code = ALU_SLT; w_hit = 1'b1; end
                    OPC_ANDI: begin w_code = ALU_AND; w_hit = 1'b1; end
                    OPC_ORI:  begin w_code = ALU_OR;  w_hit = 1'b1; end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign alu_ctrl_o = w_hit ? w_code : DEFAULT_CTRL;
    assign illegal_o  = ~w_hit;

endmodule

`default_nettype wire

// File: rtl/alu_control.sv
// ============================================================================
// Module      : alu_control
// Description : Registered ALU-control decoder (1-cycle latency, sync reset).
//               Optional XOR/NOR extension via macro ALU_CONTROL_LOGIC_EXT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_control
    import alu_control_pkg::*;
#(
    parameter logic [3:0] RESET_CTRL   = 4'b0000,
    parameter logic [3:0] DEFAULT_CTRL = 4'b0010
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] alu_op_i,
    input  logic [3:0] opcode_i,
    input  logic [1:0] funct_i,
    output logic [3:0] alu_ctrl_o,
    output logic       illegal_o
);

    logic [3:0] alu_ctrl_d, alu_ctrl_q;
    logic       illegal_d,  illegal_q;

    alu_control_decode #(
        .DEFAULT_CTRL (DEFAULT_CTRL)
    ) u_decode (
        .alu_op_i   (alu_op_i),
        .opcode_i   (opcode_i),
        .funct_i    (funct_i),
        .alu_ctrl_o (alu_ctrl_d),
        .illegal_o  (illegal_d)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            alu_ctrl_q <= RESET_CTRL;
            illegal_q  <= 1'b0;
        end else begin
            alu_ctrl_q <= alu_ctrl_d;
            illegal_q  <= illegal_d;
        end
    end

    assign alu_ctrl_o = alu_ctrl_q;
    assign illegal_o  = illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_control.sv
// ============================================================================
// Module      : tb_alu_control
// Description : Self-checking bench: table-driven reference model plus
//               directed literal checks, exhaustive sweep and random stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_control;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] op;
    logic [3:0] opc;
    logic [1:0] fn;
    logic [3:0] ctrl;
    logic       ill;

    int checks   = 0;
    int failures = 0;

    alu_control dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .alu_op_i   (op),
        .opcode_i   (opc),
        .funct_i    (fn),
        .alu_ctrl_o (ctrl),
        .illegal_o  (ill)
    );

    always #5 clk = ~clk;

    // Legal R/I encodings as a lookup table; anything not listed is illegal.
    typedef struct {
        logic [1:0] op;
        logic [3:0] opc;
        logic [1:0] fn;
        bit         fn_care;
        logic [3:0] code;
    } ent_t;

    ent_t tbl[$];

    function automatic logic [4:0] model(input logic [1:0] o, input logic [3:0] oc,
                                         input logic [1:0] f);
        if (o == 2'b00) return {1'b0, 4'b0010};
        if (o == 2'b01) return {1'b0, 4'b0110};
        foreach (tbl[k]) begin
            if (tbl[k].op == o && tbl[k].opc == oc && (!tbl[k].fn_care || tbl[k].fn == f))
                return {1'b0, tbl[k].code};
        end
        return {1'b1, 4'b0010};
    endfunction

    logic [3:0] exp_ctrl;
    logic       exp_ill;
    bit         exp_valid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            exp_ctrl <= 4'b0000;
            exp_ill  <= 1'b0;
        end else begin
            {exp_ill, exp_ctrl} <= model(op, opc, fn);
        end
        exp_valid <= 1'b1;
    end

    always @(negedge clk) begin
        if (exp_valid) begin
            checks++;
            if (ctrl !== exp_ctrl || ill !== exp_ill) begin
                failures++;
                $display("FAIL model t=%0t op=%b opc=%b fn=%b: got ctrl=%b ill=%b, want ctrl=%b ill=%b",
                         $time, op, opc, fn, ctrl, ill, exp_ctrl, exp_ill);
            end
        end
    end

    task automatic step(input logic r, input logic [1:0] o, input logic [3:0] oc,
                        input logic [1:0] f);
        rst = r; op = o; opc = oc; fn = f;
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [3:0] c, input logic i);
        checks++;
        if (ctrl !== c || ill !== i) begin
            failures++;
            $display("FAIL %s: got ctrl=%b ill=%b, want ctrl=%b ill=%b", name, ctrl, ill, c, i);
        end
    endtask

    initial begin
        tbl.push_back('{2'b10, 4'b0000, 2'b00, 1'b1, 4'b0010});
        tbl.push_back('{2'b10, 4'b0000, 2'b01, 1'b1, 4'b0110});
        tbl.push_back('{2'b10, 4'b0000, 2'b10, 1'b1, 4'b0111});
        tbl.push_back('{2'b10, 4'b0001, 2'b00, 1'b1, 4'b0000});
        tbl.push_back('{2'b10, 4'b0001, 2'b01, 1'b1, 4'b0001});
        tbl.push_back('{2'b10, 4'b0010, 2'b00, 1'b1, 4'b1000});
        tbl.push_back('{2'b10, 4'b0010, 2'b01, 1'b1, 4'b1001});
`ifdef ALU_CONTROL_LOGIC_EXT_EN
        tbl.push_back('{2'b10, 4'b0010, 2'b10, 1'b1, 4'b0011});
        tbl.push_back('{2'b10, 4'b0010, 2'b11, 1'b1, 4'b1100});
`endif
        tbl.push_back('{2'b11, 4'b1001, 2'b00, 1'b0, 4'b0010});
        tbl.push_back('{2'b11, 4'b1010, 2'b00, 1'b0, 4'b0111});
        tbl.push_back('{2'b11, 4'b1011, 2'b00, 1'b0, 4'b0000});
        tbl.push_back('{2'b11, 4'b1100, 2'b00, 1'b0, 4'b0001});

        rst = 1'b1;
        op  = 2'($urandom);
        opc = 4'($urandom);
        fn  = 2'($urandom);
        @(negedge clk);
        @(negedge clk);
        check("reset", 4'b0000, 1'b0);

        step(1'b0, 2'b00, 4'bxxxx, 2'bxx); check("mem_add", 4'b0010, 1'b0);
        step(1'b0, 2'b01, 4'bxxxx, 2'bxx); check("br_sub",  4'b0110, 1'b0);

        step(1'b0, 2'b10, 4'b0000, 2'b00); check("r_add", 4'b0010, 1'b0);
        step(1'b0, 2'b10, 4'b0000, 2'b01); check("r_sub", 4'b0110, 1'b0);
        step(1'b0, 2'b10, 4'b0000, 2'b10); check("r_slt", 4'b0111, 1'b0);
        step(1'b0, 2'b10, 4'b0001, 2'b00); check("r_and", 4'b0000, 1'b0);
        step(1'b0, 2'b10, 4'b0001, 2'b01); check("r_or",  4'b0001, 1'b0);
        step(1'b0, 2'b10, 4'b0010, 2'b00); check("r_sll", 4'b1000, 1'b0);
        step(1'b0, 2'b10, 4'b0010, 2'b01); check("r_srl", 4'b1001, 1'b0);

        step(1'b0, 2'b11, 4'b1001, 2'bxx); check("i_addi", 4'b0010, 1'b0);
        step(1'b0, 2'b11, 4'b1010, 2'bxx); check("i_slti", 4'b0111, 1'b0);
        step(1'b0, 2'b11, 4'b1011, 2'bxx); check("i_andi", 4'b0000, 1'b0);
        step(1'b0, 2'b11, 4'b1100, 2'bxx); check("i_ori",  4'b0001, 1'b0);

        step(1'b0, 2'b10, 4'b0000, 2'b11); check("ill_r_f3",   4'b0010, 1'b1);
        step(1'b0, 2'b10, 4'b0101, 2'b00); check("ill_r_opc",  4'b0010, 1'b1);
        step(1'b0, 2'b11, 4'b0011, 2'b00); check("ill_i_opc",  4'b0010, 1'b1);
        step(1'b0, 2'b10, 4'b0001, 2'b10); check("ill_logic",  4'b0010, 1'b1);
`ifdef ALU_CONTROL_LOGIC_EXT_EN
        step(1'b0, 2'b10, 4'b0010, 2'b10); check("ext_xor", 4'b0011, 1'b0);
        step(1'b0, 2'b10, 4'b0010, 2'b11); check("ext_nor", 4'b1100, 1'b0);
`else
        step(1'b0, 2'b10, 4'b0010, 2'b10); check("noext_f2", 4'b0010, 1'b1);
        step(1'b0, 2'b10, 4'b0010, 2'b11); check("noext_f3", 4'b0010, 1'b1);
`endif

        step(1'b0, 2'b01, 4'b0000, 2'b00); check("pre_rst_sub", 4'b0110, 1'b0);
        step(1'b1, 2'b10, 4'b0101, 2'b11); check("mid_reset",   4'b0000, 1'b0);
        step(1'b0, 2'b00, 4'b1111, 2'b11); check("post_reset",  4'b0010, 1'b0);

        for (int i = 0; i < 256; i++) begin
            step(1'b0, i[7:6], i[5:2], i[1:0]);
        end

        for (int n = 0; n < 600; n++) begin
            step(($urandom_range(0, 19) == 0), 2'($urandom), 4'($urandom), 2'($urandom));
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_control.md
Name: alu_control

Overview:
- Registered ALU-control decoder for the 16-bit single-issue CPU; sits between the main control unit and the ALU.
- Maps the main-control ALUOp class, the 4-bit instruction Opcode and the 2-bit R-type Funct to a 4-bit ALU operation code (ALUCtrl).
- Flags unsupported encodings.
- Output is registered: one clock of latency, synchronous active-high reset.

Parameters:
- RESET_CTRL, 4'b0000: ALUCtrl value while in reset.
- DEFAULT_CTRL, 4'b0010: ALUCtrl issued for any illegal encoding (ADD).

Ports:
- Clock  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- ALUOp  input  2  operation class from main control.
- Opcode  input  4  instruction opcode field [15:12].
- Funct  input  2  R-type function field.
- ALUCtrl  output  4  registered ALU operation select.
- Illegal  output  1  registered; 1 when the sampled combination is undecodable.

Behaviour:
- ALU codes (package constants): AND=0000, OR=0001, ADD=0010, XOR=0011, SLL=1000, SRL=1001, SUB=0110, SLT=0111, NOR=1100.
- Decode is combinational, then registered on the Clock rising edge. ALUCtrl and Illegal reflect the inputs sampled at the previous edge (latency 1).
- Reset=1 at an edge: ALUCtrl<=RESET_CTRL and Illegal<=0. Reset has priority over decode. Reset is ignored between edges.
- ALUOp=00 (load/store address): ADD. Opcode and Funct are ignored.
- ALUOp=01 (branch compare): SUB. Opcode and Funct are ignored.
- ALUOp=10 (R-type), keyed on Opcode, then Funct:
  - 0000: 00→ADD, 01→SUB, 10→SLT, 11→illegal.
  - 0001: 00→AND, 01→OR, 10/11→illegal.
  - 0010: 00→SLL, 01→SRL, 10/11→illegal unless the optional feature is enabled.
  - Any other Opcode: illegal.
- ALUOp=11 (I-type), keyed on Opcode only; Funct is don't-care and may be X/Z without affecting the result:
  - 1001 (ADDI)→ADD
  - 1010 (SLTI)→SLT
  - 1011 (ANDI)→AND
  - 1100 (ORI)→OR
  - Any other Opcode: illegal.
- Illegal decode: ALUCtrl<=DEFAULT_CTRL and Illegal<=1.
- Inputs that are don't-care for the chosen class must not propagate X to the outputs. Use case/casez with a default branch.
- No internal state other than the two output registers.

Optional Feature:
- Macro ALU_CONTROL_LOGIC_EXT_EN.
- Defined: ALUOp=10, Opcode=0010, Funct=10→XOR and Funct=11→NOR, with Illegal=0.
- Undefined: those two encodings decode as illegal (DEFAULT_CTRL, Illegal=1).
- All other behaviour is identical in both builds.

Decomposition:
- Package alu_control_pkg holds:
  - ALUOp class constants (ALUOP_MEM=00, ALUOP_BR=01, ALUOP_R=10, ALUOP_I=11).
  - Opcode constants.
  - Funct constants.
  - A 4-bit ALU-code typedef with the operation constants listed above.
- One natural sub-module, alu_control_decode: purely combinational, outputs next ALUCtrl and Illegal. The top level instantiates it and adds the output registers.

Test Plan:
- Reset=1 for 2 cycles with arbitrary inputs → ALUCtrl=0000, Illegal=0. Release Reset with ALUOp=00 → next edge ALUCtrl=0010.
- ALUOp=00 then 01, with Opcode/Funct=X → ALUCtrl=0010 then 0110, one cycle after each input change, Illegal=0.
- R-type sweep (ALUOp=10):
  - Opcode 0000 / Funct 00,01,10 → 0010, 0110, 0111.
  - Opcode 0001 / Funct 00,01 → 0000, 0001.
  - Opcode 0010 / Funct 00,01 → 1000, 1001.
- I-type with Funct=XX: ALUOp=11, Opcode 1001, 1010, 1011, 1100 → 0010, 0111, 0000, 0001, no X on outputs.
- Illegal cases → ALUCtrl=0010, Illegal=1:
  - ALUOp=10, Opcode=0000, Funct=11.
  - ALUOp=10, Opcode=0101.
  - ALUOp=11, Opcode=0011.
  - ALUOp=10, Opcode=0010, Funct=10: illegal without the macro; with ALU_CONTROL_LOGIC_EXT_EN it gives 0011 and Funct=11 gives 1100, Illegal=0.
- Reset asserted mid-stream (ALUCtrl currently 0110) → next edge ALUCtrl=0000, Illegal=0. Decode resumes the edge after release.
